// File: rtl/enc_dec_pkg.sv
// Shared definitions for the index/one-hot encoder-decoder family.
// Holds default widths, the decoder FSM states and the golden index-to-one-hot decode.
package enc_dec_pkg;

  localparam int OUT_W_DEF  = 8;
  localparam int CODE_W_DEF = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } dec_state_e;

  function automatic logic [OUT_W_DEF-1:0] idx_to_onehot(input logic [CODE_W_DEF-1:0] code);
    logic [OUT_W_DEF-1:0] w_word;
    w_word       = {OUT_W_DEF{1'b0}};
    w_word[code] = 1'b1;
    return w_word;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous code buffer; an extra pointer bit separates full from empty.
// Pushes while full and pops while empty are ignored.
module code_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_diff;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_level   = LVL_W'(w_diff);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer and storage update; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_mem    <= '{default: {WIDTH{1'b0}}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/onehot_hold_decoder.sv
// Buffers index codes and replays each as a one-hot word held for HOLD_CYC cycles,
// with a sticky mask of every line shown since reset or the last clear.
module onehot_hold_decoder
  import enc_dec_pkg::*;
#(
  parameter int OUT_W      = OUT_W_DEF,
  parameter int CODE_W     = CODE_W_DEF,
  parameter int HOLD_CYC   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [OUT_W-1:0]  onehot_out,
  output logic              out_valid,
  output logic              busy,
  output logic [OUT_W-1:0]  sticky,
  input  logic              sticky_clr,
  output logic [CODE_W-1:0] fifo_level
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  dec_state_e       r_state;
  dec_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] r_onehot;
  logic [OUT_W-1:0] w_onehot_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [OUT_W-1:0] r_sticky;
  logic [OUT_W-1:0] w_sticky_nxt;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CODE_W-1:0] w_head;
  logic [LVL_W-1:0]  w_level;

  // Ready is a function of buffer state only, and is held low while in reset.
  assign code_ready = !w_full && !rst;
  assign onehot_out = r_onehot;
  assign out_valid  = r_valid;
  assign sticky     = r_sticky;
  assign busy       = !w_empty || (r_state == ST_HOLD);
  assign fifo_level = CODE_W'(w_level);

  code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (code_valid && code_ready),
    .i_data  (code_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next-state, hold counter, output word and sticky mask.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = r_onehot;
    w_valid_nxt  = r_valid;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_onehot_nxt = idx_to_onehot(w_head);
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = ST_HOLD;
        end else begin
          w_onehot_nxt = {OUT_W{1'b0}};
          w_valid_nxt  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!w_empty) begin
          // Reload straight from the buffer so consecutive words have no gap.
          w_pop        = 1'b1;
          w_onehot_nxt = idx_to_onehot(w_head);
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
        end else begin
          w_onehot_nxt = {OUT_W{1'b0}};
          w_valid_nxt  = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_onehot_nxt = {OUT_W{1'b0}};
        w_valid_nxt  = 1'b0;
        w_cnt_nxt    = {CNT_W{1'b0}};
        w_state_nxt  = ST_IDLE;
      end
    endcase

    // Clear takes effect before the new word is merged in.
    w_sticky_nxt = sticky_clr ? {OUT_W{1'b0}} : r_sticky;
    if (w_pop) begin
      w_sticky_nxt = w_sticky_nxt | w_onehot_nxt;
    end else begin
      w_sticky_nxt = w_sticky_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, hold counter and sticky mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_onehot <= {OUT_W{1'b0}};
      r_valid  <= 1'b0;
      r_sticky <= {OUT_W{1'b0}};
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_valid  <= w_valid_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Self-checking bench: each accepted code is given a display slot
// [start, start+HOLD) with start = max(accept_edge+1, end of previous slot).
module tb_onehot_hold_decoder;

  localparam int OUT_W = 8;
  localparam int CODE_W = 3;
  localparam int HOLD = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] code_in = 3'd0;
  logic              code_valid = 1'b0;
  logic              code_ready;
  logic [OUT_W-1:0]  onehot_out;
  logic              out_valid;
  logic              busy;
  logic [OUT_W-1:0]  sticky;
  logic              sticky_clr = 1'b0;
  logic [CODE_W-1:0] fifo_level;

  always #5 clk = ~clk;

  onehot_hold_decoder #(
    .OUT_W      (OUT_W),
    .CODE_W     (CODE_W),
    .HOLD_CYC   (HOLD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .onehot_out (onehot_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .fifo_level (fifo_level)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;
  int last_clr = 0;
  int prev_end = 0;
  int q_code[$];
  int q_start[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  function automatic int pending_after(int t);
    int n = 0;
    foreach (q_start[i]) if (q_start[i] > t) n++;
    return n;
  endfunction

  task automatic check_all();
    logic [OUT_W-1:0] w_exp;
    logic [OUT_W-1:0] s_exp;
    int lvl;
    w_exp = '0;
    s_exp = '0;
    lvl = pending_after(e);
    foreach (q_start[i]) begin
      if (q_start[i] <= e) begin
        if (e < q_start[i] + HOLD) w_exp = 8'(1 << q_code[i]);
        if (q_start[i] >= last_clr) s_exp = s_exp | 8'(1 << q_code[i]);
      end
    end
    chk("onehot_out", 32'(onehot_out), 32'(w_exp));
    chk("out_valid", 32'(out_valid), 32'(w_exp != 8'h00));
    chk("fifo_level", 32'(fifo_level), 32'(lvl));
    chk("code_ready", 32'(code_ready), 32'((lvl < DEPTH) && !rst));
    chk("busy", 32'(busy), 32'((lvl > 0) || (w_exp != 8'h00)));
    chk("sticky", 32'(sticky), 32'(s_exp));
    chk("onehot0", 32'($onehot0(onehot_out)), 32'd1);
  endtask

  task automatic tick(input logic v, input logic [CODE_W-1:0] c, input logic clr, input logic r);
    int lvl;
    int s;
    code_valid = v;
    code_in = c;
    sticky_clr = clr;
    rst = r;
    lvl = pending_after(e);
    e++;
    if (r) begin
      q_code.delete();
      q_start.delete();
      prev_end = 0;
      last_clr = e;
    end else begin
      if (v && lvl < DEPTH) begin
        s = (e + 1 > prev_end) ? e + 1 : prev_end;
        q_code.push_back(int'(c));
        q_start.push_back(s);
        prev_end = s + HOLD;
      end
      if (clr) last_clr = e;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int s;
    // Reset and idle
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    tick(1'b1, 3'd6, 1'b0, 1'b1);
    idle(2);

    // Single code
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    idle(7);
    chk("single_sticky", 32'(sticky), 32'h20);
    chk("single_busy", 32'(busy), 32'd0);

    // Back-to-back
    tick(1'b1, 3'd7, 1'b0, 1'b0);
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd3, 1'b0, 1'b0);
    idle(14);

    // Full FIFO: sixth push must be refused
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 3'(i + 1), 1'b0, 1'b0);
      if (i == 4) chk("full_ready", 32'(code_ready), 32'd0);
    end
    idle(26);

    // Sticky clear colliding with a pop
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    tick(1'b1, 3'd1, 1'b0, 1'b0);
    s = q_start[q_start.size() - 1];
    while (e + 1 < s) idle(1);
    chk("sticky_pre", 32'(sticky), 32'h21);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    chk("sticky_collide", 32'(sticky), 32'h02);
    idle(6);

    // Reset mid-hold with three codes queued
    for (int i = 0; i < 4; i++) tick(1'b1, 3'(7 - i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    tick(1'b1, 3'd2, 1'b0, 1'b1);
    chk("rst_onehot", 32'(onehot_out), 32'h00);
    chk("rst_level", 32'(fifo_level), 32'd0);
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_hold_decoder.md
Name: onehot_hold_decoder

Overview:
- Inverse of the 8-to-3 priority encoder: takes 3-bit index codes and regenerates an 8-bit one-hot output.
- Codes arrive on a valid/ready stream and are buffered in a small FIFO.
- Each decoded one-hot word is held for a programmable number of cycles, so downstream slow logic (LED/strobe drivers, interrupt lines) sees every event.
- A sticky mask records every line decoded since the last clear.

Parameters:
- OUT_W, 8: one-hot output width; must be a power of 2.
- CODE_W, 3: code width; equals log2(OUT_W).
- HOLD_CYC, 4: cycles each one-hot word is driven; minimum 1.
- FIFO_DEPTH, 4: code buffer entries; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- code_in  input  CODE_W  index to decode (7 -> bit 7).
- code_valid  input  1  code_in valid this cycle.
- code_ready  output  1  FIFO can accept; equals !full.
- onehot_out  output  OUT_W  decoded one-hot word; all-zero when idle.
- out_valid  output  1  onehot_out holds a decoded word.
- busy  output  1  FIFO non-empty or FSM in HOLD.
- sticky  output  OUT_W  OR of all words shown since reset or clear.
- sticky_clr  input  1  clear sticky (one-cycle pulse).
- fifo_level  output  CODE_W  current FIFO occupancy (0..FIFO_DEPTH; sized to hold FIFO_DEPTH).

Behaviour:
- Single clock domain. One clock. Reset is synchronous and active-high. Every register is cleared on the clk edge where rst=1.
- Reset values:
  - onehot_out=0, out_valid=0, busy=0, sticky=0, fifo_level=0.
  - code_ready=1 after reset (low only during the reset cycle itself).
  - FIFO pointers=0, FSM=IDLE, hold counter=0.
- Accept: a push happens on an edge where code_valid && code_ready.
  - code_ready depends only on FIFO state, never combinationally on code_valid.
  - When full, code_ready=0. A push is not accepted even if a pop occurs on the same edge (no pass-through on full).
  - Push and pop on the same edge while not full: both occur, and the level is unchanged.
- FSM states: IDLE and HOLD.
  - IDLE: if FIFO non-empty, pop the head. onehot_out <= 1<<code, out_valid <= 1, counter <= HOLD_CYC-1, go to HOLD. Otherwise onehot_out=0 and out_valid=0.
  - HOLD, counter != 0: decrement the counter and keep the output.
  - HOLD, counter == 0 and FIFO non-empty: pop the next code and load it directly. There are no zero cycles between words. Stay in HOLD and reload the counter.
  - HOLD, counter == 0 and FIFO empty: clear onehot_out and out_valid, go to IDLE.
- Latency: a code accepted at edge N into an empty, idle block appears on onehot_out after edge N+1, so it is visible in the cycle following N+1. It is held for exactly HOLD_CYC cycles.
- HOLD_CYC=1: every word shows for one cycle. Back-to-back codes produce a continuous stream with no gaps.
- sticky: ORs in the new one-hot word on every pop edge.
  - sticky_clr clears it.
  - sticky_clr and a pop on the same edge: sticky becomes exactly the new word (clear first, then set).
- Any CODE_W value is legal. With OUT_W=2^CODE_W there are no invalid codes and no error path.
- onehot_out always has exactly 0 or 1 bits set. Assert $onehot0 in simulation.
- FIFO pointers wrap modulo FIFO_DEPTH. Use an extra pointer bit to distinguish full from empty.
- rst mid-HOLD or with a partly full FIFO: on the next edge all contents are discarded and outputs return to their reset values. Codes presented during rst are not accepted.

Decomposition:
- Shared package (enc_dec_pkg):
  - OUT_W and CODE_W defaults.
  - FSM state enum (IDLE, HOLD).
  - A decode function idx_to_onehot(code), reused by the priority-encoder testbench as its golden inverse model.
- One sub-module: code_fifo, a synchronous FIFO parameterized by width and depth. It provides push, pop, full, empty and level.
- FSM, hold counter and sticky logic stay in the top.

Test Plan:
- Reset and idle: assert rst 2 cycles, release -> onehot_out=0x00, out_valid=0, code_ready=1, fifo_level=0, sticky=0x00.
- Single code: push 3'd5 at edge N, HOLD_CYC=4 -> onehot_out=0x20 in the 4 cycles after N+1, then 0x00. Also sticky=0x20 and busy low after the hold ends.
- Back-to-back: push 7,0,3 on consecutive edges -> 0x80 x4, 0x01 x4, 0x08 x4 contiguous with no zero cycle between words. fifo_level peaks at 2.
- Full FIFO: push 6 codes while holding -> code_ready=0 once fifo_level=4. The extra push is ignored. Exactly 5 words are output, in order.
- Sticky clear collision: sticky=0x21, then pulse sticky_clr on the same edge as popping code 1 -> sticky=0x02.
- Reset mid-operation: rst during HOLD with 3 codes queued -> next cycle onehot_out=0, fifo_level=0. No stale word appears afterward.
